// File: rtl/battle_pkg.sv
// Shared definitions for the battle frame sequencer: phase indices and FSM states.
package battle_pkg;

    // Phase index, also the bit position in phStart / phAck / phDone / timeoutFlags.
    typedef enum logic [1:0] {
        PH_FRONT  = 2'd0,
        PH_DAMAGE = 2'd1,
        PH_MOVE   = 2'd2,
        PH_SPAWN  = 2'd3
    } ph_idx_e;

    // RUN and ACK are shared by all four phases; the phase index rides alongside.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ACK  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_e;

    // One-hot strobe vector for a phase index.
    function automatic logic [3:0] ph_onehot(input ph_idx_e idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/battle_frame_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter
    import battle_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    // Clear first, then count up unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end
        if (inc && (count_d != {CNT_W{1'b1}})) begin
            count_d = count_d + 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/battle_frame_sequencer.sv
// Per-frame phase scheduler: on each accepted tick it handshakes FRONT, DAMAGE, MOVE
// and SPAWN in order, buffers one early tick, counts dropped ticks and frames, and
// force-acks any phase whose Done does not arrive within TIMEOUT cycles.
module battle_frame_sequencer
    import battle_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frameTick,
    input  logic             pause,
    input  logic [3:0]       phDone,
    input  logic             clrErr,
    output logic [3:0]       phStart,
    output logic [3:0]       phAck,
    output logic             busy,
    output logic             frameDone,
    output logic [CNT_W-1:0] frameCount,
    output logic [CNT_W-1:0] overrunCount,
    output logic [3:0]       timeoutFlags
);

    localparam int             TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    ph_idx_e       ph_q, ph_d;
    logic          pending_q, pending_d;
    logic          busy_q, busy_d;
    logic [3:0]    ph_start_q, ph_start_d;
    logic [3:0]    ph_ack_q, ph_ack_d;
    logic          frame_done_q, frame_done_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [3:0]    flags_q, flags_d;
    ph_idx_e       ph_next;
    logic          frame_inc;
    logic          over_inc;

    assign ph_next   = ph_idx_e'(ph_q + 2'd1);
    assign frame_inc = (state_q == ST_FIN);
    // A tick while a frame runs and one is already buffered is lost.
    assign over_inc  = frameTick & busy_q & pending_q;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        pending_d    = pending_q;
        busy_d       = busy_q;
        ph_start_d   = '0;
        ph_ack_d     = '0;
        frame_done_d = 1'b0;
        wait_d       = wait_q;
        flags_d      = clrErr ? 4'b0000 : flags_q;

        // Buffer the first early tick of a running frame.
        if (frameTick && busy_q && !pending_q) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frameTick && pause) begin
                    pending_d = 1'b1;
                end
                if ((frameTick || pending_q) && !pause) begin
                    state_d    = ST_RUN;
                    ph_d       = PH_FRONT;
                    pending_d  = 1'b0;
                    busy_d     = 1'b1;
                    wait_d     = '0;
                    ph_start_d = ph_onehot(PH_FRONT);
                end
            end
            ST_RUN: begin
                if (phDone[ph_q]) begin
                    state_d  = ST_ACK;
                    ph_ack_d = ph_onehot(ph_q);
                end else if (wait_q == WAIT_LAST) begin
                    // Timeout set wins over a same-cycle clear for this bit.
                    flags_d[ph_q] = 1'b1;
                    state_d       = ST_ACK;
                    ph_ack_d      = ph_onehot(ph_q);
                end else begin
                    wait_d     = wait_q + 1'b1;
                    ph_start_d = ph_onehot(ph_q);
                end
            end
            ST_ACK: begin
                if (ph_q == PH_SPAWN) begin
                    state_d = ST_FIN;
                end else begin
                    state_d    = ST_RUN;
                    ph_d       = ph_next;
                    wait_d     = '0;
                    ph_start_d = ph_onehot(ph_next);
                end
            end
            ST_FIN: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; all drop immediately on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ph_q         <= PH_FRONT;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            ph_start_q   <= '0;
            ph_ack_q     <= '0;
            frame_done_q <= 1'b0;
            wait_q       <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            ph_start_q   <= ph_start_d;
            ph_ack_q     <= ph_ack_d;
            frame_done_q <= frame_done_d;
            wait_q       <= wait_d;
            flags_q      <= flags_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_inc),
        .clr   (1'b0),
        .count (frameCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_overrun_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (over_inc),
        .clr   (clrErr),
        .count (overrunCount)
    );

    assign phStart      = ph_start_q;
    assign phAck        = ph_ack_q;
    assign busy         = busy_q;
    assign frameDone    = frame_done_q;
    assign timeoutFlags = flags_q;

endmodule

// File: tb/tb_battle_frame_sequencer.sv
// Directed bench for battle_frame_sequencer with behavioural phase engines.
// Cycle numbering: cyc is the period following the cyc-th clock edge after reset
// release; a tick driven in period 10 launches RUN(FRONT) in period 11.
module tb_battle_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: TIMEOUT=8, CNT_W=16
    logic        tick_a = 1'b0, pause_a = 1'b0, clr_a = 1'b0;
    logic [3:0]  hang_a = 4'b0000;
    logic [3:0]  done_a, start_a, ack_a, flags_a;
    logic        busy_a, fdone_a;
    logic [15:0] fcnt_a, ocnt_a;

    // DUT B: TIMEOUT=8, CNT_W=2
    logic        tick_b = 1'b0, pause_b = 1'b0, clr_b = 1'b0;
    logic [3:0]  hang_b = 4'b0000;
    logic [3:0]  done_b, start_b, ack_b, flags_b;
    logic        busy_b, fdone_b;
    logic [1:0]  fcnt_b, ocnt_b;

    int cyc;
    int n_vec = 0;
    int n_err = 0;

    int st_first[4];
    int st_len[4];
    int ack_first[4];
    int rise0[2];
    int done_at[2];
    int n_done;
    int n_rise0;
    int overlap;

    battle_frame_sequencer #(.TIMEOUT(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .frameTick(tick_a), .pause(pause_a), .phDone(done_a),
        .clrErr(clr_a), .phStart(start_a), .phAck(ack_a), .busy(busy_a),
        .frameDone(fdone_a), .frameCount(fcnt_a), .overrunCount(ocnt_a),
        .timeoutFlags(flags_a)
    );

    battle_frame_sequencer #(.TIMEOUT(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .frameTick(tick_b), .pause(pause_b), .phDone(done_b),
        .clrErr(clr_b), .phStart(start_b), .phAck(ack_b), .busy(busy_b),
        .frameDone(fdone_b), .frameCount(fcnt_b), .overrunCount(ocnt_b),
        .timeoutFlags(flags_b)
    );

    // Zero-wait engines: Done pulses the cycle after Start is seen, unless hung.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_a <= 4'b0000;
            done_b <= 4'b0000;
        end else begin
            done_a <= start_a & ~done_a & ~hang_a;
            done_b <= start_b & ~done_b & ~hang_b;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, required %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick_a = 1'b0; pause_a = 1'b0; clr_a = 1'b0; hang_a = 4'b0000;
        tick_b = 1'b0; pause_b = 1'b0; clr_b = 1'b0; hang_b = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Observe DUT A each period until 'frames' frameDone pulses; drive ticks at given cycles.
    task automatic watch_a(input int frames, input int budget, input int tk0, input int tk1, input int tk2);
        logic [3:0] prev;
        int spent;
        prev = 4'b0000;
        n_done = 0; n_rise0 = 0; overlap = 0; spent = 0;
        for (int k = 0; k < 4; k++) begin
            st_first[k] = -1; st_len[k] = 0; ack_first[k] = -1;
        end
        rise0[0] = -1; rise0[1] = -1; done_at[0] = -1; done_at[1] = -1;
        while (n_done < frames && spent < budget) begin
            @(negedge clk);
            spent++;
            for (int k = 0; k < 4; k++) begin
                if (start_a[k]) begin
                    st_len[k]++;
                    if (st_first[k] < 0) st_first[k] = cyc;
                end
                if (ack_a[k] && ack_first[k] < 0) ack_first[k] = cyc;
            end
            if ($countones(start_a) > 1 || $countones(ack_a) > 1 || (start_a != 0 && ack_a != 0))
                overlap++;
            if (start_a[0] && !prev[0] && n_rise0 < 2) begin
                rise0[n_rise0] = cyc;
                n_rise0++;
            end
            prev = start_a;
            if (fdone_a && n_done < 2) begin
                done_at[n_done] = cyc;
                n_done++;
            end
            tick_a = (cyc == tk0 || cyc == tk1 || cyc == tk2);
        end
        tick_a = 1'b0;
        chk("frames_completed", n_done, frames);
    endtask

    initial begin
        int seen;
        int t;
        int got;
        int found;

        // ---- 1: reset state and a single zero-wait frame ----
        do_reset();
        chk("rst_start_ack", {start_a, ack_a}, 0);
        chk("rst_busy_done", {busy_a, fdone_a}, 0);
        chk("rst_frame_cnt", fcnt_a, 0);
        chk("rst_overrun_cnt", ocnt_a, 0);
        chk("rst_flags", flags_a, 0);
        watch_a(1, 60, 10, -1, -1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_start%0d_cycle", k), st_first[k], 11 + 3 * k);
            chk($sformatf("t1_start%0d_len", k), st_len[k], 2);
            chk($sformatf("t1_ack%0d_cycle", k), ack_first[k], 13 + 3 * k);
        end
        chk("t1_frame_done_cycle", done_at[0], 24);
        chk("t1_busy_after", busy_a, 0);
        chk("t1_overlap", overlap, 0);
        chk("t1_frame_cnt", fcnt_a, 1);
        chk("t1_flags", flags_a, 0);

        // ---- 2: DAMAGE hangs, forced abort after 8 cycles ----
        do_reset();
        hang_a = 4'b0010;
        watch_a(1, 80, 10, -1, -1);
        chk("t2_damage_len", st_len[1], 8);
        chk("t2_move_start", st_first[2], 23);
        chk("t2_move_len", st_len[2], 2);
        chk("t2_spawn_start", st_first[3], 26);
        chk("t2_spawn_len", st_len[3], 2);
        chk("t2_frame_done_cycle", done_at[0], 30);
        chk("t2_flags", flags_a, 4'b0010);
        chk("t2_frame_cnt", fcnt_a, 1);
        chk("t2_overlap", overlap, 0);
        hang_a = 4'b0000;

        // ---- 3: three ticks 2 cycles apart: one buffered, one dropped ----
        do_reset();
        watch_a(2, 100, 10, 12, 14);
        chk("t3_frame1_done", done_at[0], 24);
        chk("t3_frame2_start", rise0[1], 25);
        chk("t3_frame2_done", done_at[1], 38);
        chk("t3_overrun_cnt", ocnt_a, 1);
        chk("t3_frame_cnt", fcnt_a, 2);

        // ---- 4: pause blocks launch; frame starts 1 cycle after pause falls ----
        do_reset();
        @(negedge clk);
        pause_a = 1'b1;
        tick_a  = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (start_a != 0 || busy_a) seen++;
        end
        chk("t4_no_start_paused", seen, 0);
        t = cyc;
        pause_a = 1'b0;
        watch_a(1, 60, -1, -1, -1);
        chk("t4_launch_cycle", st_first[0], t + 1);
        chk("t4_frame_done_cycle", done_at[0], t + 14);
        chk("t4_frame_cnt", fcnt_a, 1);

        // ---- 5: async reset during RUN(MOVE), then a clean frame ----
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (start_a[2]) found = 1;
            tick_a = (cyc == 10);
        end
        tick_a = 1'b0;
        chk("t5_reached_move", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_start", start_a, 0);
        chk("t5_async_busy", busy_a, 0);
        @(negedge clk);
        rst = 1'b1;
        watch_a(1, 60, 10, -1, -1);
        chk("t5_frame_done_cycle", done_at[0], 24);
        chk("t5_frame_cnt", fcnt_a, 1);

        // ---- 6: CNT_W=2 saturation, overrun with clear, flag clear ----
        for (int f = 1; f <= 5; f++) begin
            if (f == 5) hang_b = 4'b1000;
            @(negedge clk);
            tick_b = 1'b1;
            got = 0;
            for (int r = 1; r <= 60 && got == 0; r++) begin
                @(negedge clk);
                tick_b = (f == 5) && (r == 2 || r == 4 || r == 6 || r == 8);
                clr_b  = (f == 5) && (r == 8);
                if (fdone_b) got = 1;
            end
            tick_b = 1'b0;
            clr_b  = 1'b0;
            chk($sformatf("t6_frame%0d_done", f), got, 1);
            if (f == 3) chk("t6_count_at_3", fcnt_b, 3);
        end
        hang_b = 4'b0000;
        chk("t6_count_sat", fcnt_b, 3);
        chk("t6_flags_spawn", flags_b, 4'b1000);
        chk("t6_overrun_clr_inc", ocnt_b, 1);
        // the buffered tick runs one more frame
        got = 0;
        for (int r = 1; r <= 40 && got == 0; r++) begin
            @(negedge clk);
            if (fdone_b) got = 1;
        end
        chk("t6_frame6_done", got, 1);
        chk("t6_count_still_sat", fcnt_b, 3);
        @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("t6_flags_cleared", flags_b, 0);
        chk("t6_overrun_cleared", ocnt_b, 0);
        chk("t6_count_kept", fcnt_b, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
